// File: rtl/bf_query_engine.sv
// bf_query_engine
//
// Back end of the bloom-filter packet-match path. Each accepted op (query or
// insert) travels down a HASH_LAT-deep delay line while the external hash
// pipelines compute its two keys. When the op reaches the last stage, its keys
// are present on hashkey_a/hashkey_b. In that cycle the engine reads one bit
// from each bank and registers a tagged result. An insert also sets both bits.
// A sweep FSM zeroes the bit array after reset, and again on clr_req once all
// in-flight ops have drained.
//
// Ports:
//   CLK, RST              clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     op issue handshake (issued when both are high)
//   in_op, in_tag         0 = query / 1 = insert, opaque tag
//   hashkey_a/hashkey_b   keys for the op issued HASH_LAT cycles earlier
//   clr_req, clr_done     clear request, one-cycle pulse when the sweep ends
//   res_valid/match/op/tag  one registered result per op, no backpressure
//   insert_count          inserts since the last clear, saturating
module bf_query_engine #(
  parameter int HASH_LAT = 9,
  parameter int ADDR_W   = 12,
  parameter int TAG_W    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [31:0]      hashkey_a,
  input  logic [31:0]      hashkey_b,
  input  logic             clr_req,
  output logic             clr_done,
  output logic             res_valid,
  output logic             res_match,
  output logic             res_op,
  output logic [TAG_W-1:0] res_tag,
  output logic [15:0]      insert_count
);

  localparam int WA_W   = ADDR_W - 5;
  localparam int NWORDS = 1 << WA_W;
  localparam logic [WA_W-1:0] LAST_WORD = WA_W'(NWORDS - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [WA_W-1:0]   wcnt;
  logic              sweep_last;

  logic [HASH_LAT-1:0] vld_p;
  logic                op_p  [HASH_LAT];
  logic [TAG_W-1:0]    tag_p [HASH_LAT];

  logic [31:0] bank0 [NWORDS];
  logic [31:0] bank1 [NWORDS];

  logic            aligned, al_op, hit;
  logic [WA_W-1:0] wa_a, wa_b;
  logic [4:0]      ba_a, ba_b;
  logic            unused_key_hi;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Only the low ADDR_W key bits index the banks.
  assign unused_key_hi = ^{hashkey_a[31:ADDR_W], hashkey_b[31:ADDR_W]};

  assign wa_a = hashkey_a[ADDR_W-1:5];
  assign ba_a = hashkey_a[4:0];
  assign wa_b = hashkey_b[ADDR_W-1:5];
  assign ba_b = hashkey_b[4:0];

  assign aligned = vld_p[HASH_LAT-1];
  assign al_op   = op_p[HASH_LAT-1];
  // Reads the bank contents as they were before this cycle's insert.
  assign hit     = bank0[wa_a][ba_a] & bank1[wa_b][ba_b];

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    sweep_last = 1'b0;
    case (state_q)
      S_CLEAR: begin
        if (wcnt == LAST_WORD) begin
          sweep_last = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_IDLE: begin
        in_ready = 1'b1;
        if (clr_req) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Wait until every in-flight op has completed against the old contents.
        if (vld_p == '0) state_d = S_CLEAR;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // ---- control stage: FSM, delay-line valids, result registers ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_CLEAR;
      wcnt         <= '0;
      vld_p        <= '0;
      clr_done     <= 1'b0;
      res_valid    <= 1'b0;
      res_match    <= 1'b0;
      res_op       <= 1'b0;
      res_tag      <= '0;
      insert_count <= '0;
    end else begin
      state_q  <= state_d;
      // The counter wraps to 0 after the last word, so each sweep starts at word 0.
      wcnt     <= (state_q == S_CLEAR) ? wcnt + 1'b1 : '0;
      vld_p    <= {vld_p[HASH_LAT-2:0], in_valid & in_ready};
      clr_done <= sweep_last;
      res_valid <= aligned;
      if (aligned) begin
        res_match <= hit;
        res_op    <= al_op;
        res_tag   <= tag_p[HASH_LAT-1];
      end
      if (sweep_last)
        insert_count <= '0;
      else if (aligned && al_op)
        insert_count <= sat_inc16(insert_count);
    end
  end

  // ---- data stage: delay-line payload and bit banks ----
  always_ff @(posedge CLK) begin
    op_p[0]  <= in_op;
    tag_p[0] <= in_tag;
    for (int i = 1; i < HASH_LAT; i++) begin
      op_p[i]  <= op_p[i-1];
      tag_p[i] <= tag_p[i-1];
    end
    if (state_q == S_CLEAR) begin
      bank0[wcnt] <= '0;
      bank1[wcnt] <= '0;
    end else if (aligned && al_op) begin
      bank0[wa_a][ba_a] <= 1'b1;
      bank1[wa_b][ba_b] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bf_query_engine.sv
module tb_bf_query_engine;

  localparam int HASH_LAT = 9;
  localparam int ADDR_W   = 12;
  localparam int TAG_W    = 8;
  localparam int SWEEP    = 128;

  logic             CLK = 1'b0;
  logic             RST;
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      hashkey_a, hashkey_b;
  logic             clr_req;
  logic             clr_done;
  logic             res_valid, res_match, res_op;
  logic [TAG_W-1:0] res_tag;
  logic [15:0]      insert_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] ka_in = '0, kb_in = '0;
  logic [31:0] ka_s [HASH_LAT];
  logic [31:0] kb_s [HASH_LAT];

  typedef struct {
    int         cyc;
    logic       m;
    logic       op;
    logic [7:0] tag;
  } res_t;
  res_t rq[$];

  bf_query_engine #(.HASH_LAT(HASH_LAT), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_tag(in_tag),
    .hashkey_a(hashkey_a), .hashkey_b(hashkey_b),
    .clr_req(clr_req), .clr_done(clr_done),
    .res_valid(res_valid), .res_match(res_match), .res_op(res_op), .res_tag(res_tag),
    .insert_count(insert_count)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Stand-in for the hash pipelines: keys emerge HASH_LAT cycles after issue.
  always @(posedge CLK) begin
    ka_s[0] <= ka_in;
    kb_s[0] <= kb_in;
    for (int i = 1; i < HASH_LAT; i++) begin
      ka_s[i] <= ka_s[i-1];
      kb_s[i] <= kb_s[i-1];
    end
  end
  assign hashkey_a = ka_s[HASH_LAT-1];
  assign hashkey_b = kb_s[HASH_LAT-1];

  always @(negedge CLK)
    if (res_valid === 1'b1) rq.push_back('{cyc, res_match, res_op, res_tag});

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the op is sampled at the following posedge.
  task automatic issue(input logic op, input logic [7:0] tag, input logic [31:0] ka,
                       input logic [31:0] kb, output int icyc);
    in_valid = 1'b1;
    in_op    = op;
    in_tag   = tag;
    ka_in    = ka;
    kb_in    = kb;
    icyc     = cyc;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic check_next(input string name, input int icyc, input logic m,
                            input logic op, input logic [7:0] tag, output int rcyc);
    int   n;
    res_t r;
    n    = 0;
    rcyc = 0;
    while (rq.size() == 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (rq.size() == 0) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      r    = rq.pop_front();
      rcyc = r.cyc;
      chk({name, "_lat"},   r.cyc - icyc, 32'd10);
      chk({name, "_match"}, r.m,   m);
      chk({name, "_op"},    r.op,  op);
      chk({name, "_tag"},   r.tag, tag);
    end
  endtask

  task automatic wait_sweep(input string name);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk({name, "_len"},       n, SWEEP);
    chk({name, "_clr_done"},  clr_done, 1'b1);
    chk({name, "_count"},     insert_count, 16'd0);
    @(negedge CLK);
    chk({name, "_clr_pulse"}, clr_done, 1'b0);
    chk({name, "_ready"},     in_ready, 1'b1);
  endtask

  initial begin
    int ic, ic2, rc, rc2, n;
    RST = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_tag = '0; clr_req = 1'b0;
    repeat (3) @(negedge CLK);

    // ---- reset values ----
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_rvalid", res_valid, 1'b0);
    chk("rst_match", res_match, 1'b0);
    chk("rst_op", res_op, 1'b0);
    chk("rst_tag", res_tag, 8'h00);
    chk("rst_clr_done", clr_done, 1'b0);
    chk("rst_count", insert_count, 16'd0);

    // ---- reset release: full sweep ----
    RST = 1'b0;
    wait_sweep("init_sweep");
    chk("init_no_results", rq.size(), 32'd0);

    // ---- empty query ----
    issue(1'b0, 8'h05, 32'h0000_1234, 32'h0000_ABCD, ic);
    check_next("empty_q", ic, 1'b0, 1'b0, 8'h05, rc);

    // ---- insert, query, re-insert ----
    issue(1'b1, 8'h10, 32'h0000_1234, 32'h0000_ABCD, ic);
    check_next("ins1", ic, 1'b0, 1'b1, 8'h10, rc);
    chk("ins1_count", insert_count, 16'd1);
    issue(1'b0, 8'h11, 32'h0000_1234, 32'h0000_ABCD, ic);
    check_next("q_hit", ic, 1'b1, 1'b0, 8'h11, rc);
    chk("q_hit_count", insert_count, 16'd1);
    issue(1'b1, 8'h12, 32'h0000_1234, 32'h0000_ABCD, ic);
    check_next("reins", ic, 1'b1, 1'b1, 8'h12, rc);
    chk("reins_count", insert_count, 16'd2);

    // ---- partial hit, bank swap, high-bit aliasing ----
    issue(1'b0, 8'h13, 32'h0000_0234, 32'h0000_0BCE, ic);
    check_next("partial", ic, 1'b0, 1'b0, 8'h13, rc);
    issue(1'b0, 8'h14, 32'h0000_0BCD, 32'h0000_0234, ic);
    check_next("swapped", ic, 1'b0, 1'b0, 8'h14, rc);
    issue(1'b0, 8'h15, 32'hFFFF_1234, 32'h5555_ABCD, ic);
    check_next("alias", ic, 1'b1, 1'b0, 8'h15, rc);

    // ---- back-to-back insert then query on the same keys ----
    issue(1'b1, 8'h20, 32'h0000_0777, 32'h0000_0888, ic);
    issue(1'b0, 8'h21, 32'h0000_0777, 32'h0000_0888, ic2);
    check_next("b2b_ins", ic, 1'b0, 1'b1, 8'h20, rc);
    check_next("b2b_q", ic2, 1'b1, 1'b0, 8'h21, rc2);
    chk("b2b_consec", rc2 - rc, 32'd1);
    chk("b2b_count", insert_count, 16'd3);

    // ---- clear with three inserts in flight ----
    issue(1'b1, 8'h30, 32'h0000_0100, 32'h0000_0200, ic);
    issue(1'b1, 8'h31, 32'h0000_0101, 32'h0000_0201, ic2);
    issue(1'b1, 8'h32, 32'h0000_0102, 32'h0000_0202, n);
    @(negedge CLK);
    clr_req  = 1'b1;
    in_valid = 1'b1;             // offered alongside clr_req: must be accepted
    in_op    = 1'b0;
    in_tag   = 8'h33;
    ka_in    = 32'h0000_0101;
    kb_in    = 32'h0000_0201;
    rc2      = cyc;
    @(negedge CLK);
    clr_req  = 1'b0;
    in_valid = 1'b0;
    chk("drain_ready", in_ready, 1'b0);
    check_next("fl0", ic, 1'b0, 1'b1, 8'h30, rc);
    check_next("fl1", ic2, 1'b0, 1'b1, 8'h31, rc);
    check_next("fl2", n, 1'b0, 1'b1, 8'h32, rc);
    chk("fl_count", insert_count, 16'd6);
    check_next("fl_q", rc2, 1'b1, 1'b0, 8'h33, rc);
    n = 0;
    while (clr_done !== 1'b1 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("clr_seen", clr_done, 1'b1);
    chk("clr_bound", (n <= HASH_LAT + SWEEP + 1), 1'b1);
    chk("clr_min", (n >= SWEEP), 1'b1);
    chk("clr_count", insert_count, 16'd0);
    chk("clr_ready", in_ready, 1'b1);
    @(negedge CLK);
    issue(1'b0, 8'h40, 32'h0000_0101, 32'h0000_0201, ic);
    check_next("post_clr", ic, 1'b0, 1'b0, 8'h40, rc);
    issue(1'b0, 8'h41, 32'h0000_1234, 32'h0000_ABCD, ic);
    check_next("post_clr2", ic, 1'b0, 1'b0, 8'h41, rc);

    // ---- RST mid-sweep restarts at word 0 ----
    issue(1'b1, 8'h50, 32'h0000_0321, 32'h0000_0654, ic);
    check_next("pre_rst_ins", ic, 1'b0, 1'b1, 8'h50, rc);
    clr_req = 1'b1;
    @(negedge CLK);
    clr_req = 1'b0;
    repeat (70) @(negedge CLK);
    chk("mid_sweep_ready", in_ready, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_ready", in_ready, 1'b0);
    chk("mid_rst_count", insert_count, 16'd0);
    RST = 1'b0;
    wait_sweep("rst_sweep");
    issue(1'b0, 8'h51, 32'h0000_0321, 32'h0000_0654, ic);
    check_next("post_rst", ic, 1'b0, 1'b0, 8'h51, rc);
    chk("no_extra_results", rq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
